// File: rtl/mem_wb_pkg.sv
// Shared codes for the writeback/memory sequencer: op codes, writedata
// select codes, extender/store-size codes and the FSM state set.
// MISALIGN_CHECK_EN adds the EXC state.
package mem_wb_pkg;

  localparam logic [2:0] OP_ALU_WB = 3'b000;
  localparam logic [2:0] OP_LW     = 3'b001;
  localparam logic [2:0] OP_LH     = 3'b010;
  localparam logic [2:0] OP_LB     = 3'b011;
  localparam logic [2:0] OP_SW     = 3'b100;
  localparam logic [2:0] OP_SH     = 3'b101;
  localparam logic [2:0] OP_SB     = 3'b110;
  localparam logic [2:0] OP_RSV    = 3'b111;

  localparam logic [3:0] WD_SRC = 4'd0;
  localparam logic [3:0] WD_MEM = 4'd1;
  localparam logic [3:0] WD_EXT = 4'd2;
  localparam logic [3:0] WD_SP  = 4'd3;

  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_BYTE = 2'b01;
  localparam logic [1:0] EXT_HALF = 2'b10;

  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;

  localparam logic [4:0] SP_REG = 5'd29;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT,
    S_LATCH,
    S_WB,
    S_WR
`ifdef MISALIGN_CHECK_EN
    , S_EXC
`endif
  } state_t;

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

  // Writeback source for the op's WB cycle (ALU_WB uses the write_src mux)
  function automatic logic [3:0] wd_of(input logic [2:0] op);
    case (op)
      OP_LW:        return WD_MEM;
      OP_LH, OP_LB: return WD_EXT;
      default:      return WD_SRC;
    endcase
  endfunction

  function automatic logic [1:0] ext_of(input logic [2:0] op);
    case (op)
      OP_LH:   return EXT_HALF;
      OP_LB:   return EXT_BYTE;
      default: return EXT_NONE;
    endcase
  endfunction

  function automatic logic [1:0] st_of(input logic [2:0] op);
    case (op)
      OP_SH:   return ST_HALF;
      OP_SB:   return ST_BYTE;
      default: return ST_WORD;
    endcase
  endfunction

  // Word ops need addr[1:0]==0, half ops need addr[0]==0; bytes always fit
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      OP_LW, OP_SW: return a != 2'b00;
      OP_LH, OP_SH: return a[0];
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Loadable down-counter that times the memory read latency; zero flags
// that the read data is valid on the next edge.
module lat_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Load on op accept, count down while waiting, saturate at zero
  always_ff @(posedge clk) begin
    if (reset)                     r_cnt <= '0;
    else if (load)                 r_cnt <= load_val;
    else if (dec && r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/mem_wb_sequencer.sv
// Writeback / memory-access sequencer for the multicycle datapath.
// Moore FSM: outputs decode the registered state, forced quiet under reset.
// Optional macro MISALIGN_CHECK_EN: misaligned ops trap through EXC.
module mem_wb_sequencer
  import mem_wb_pkg::*;
#(
  parameter int         MEM_LAT     = 1,
  parameter logic [3:0] SP_INIT_SEL = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic [1:0] addr_lo,
  output logic       busy,
  output logic       done,
  output logic [3:0] wd_sel,
  output logic       reg_we,
  output logic       reg_dst_sp,
  output logic       mdr_ld,
  output logic       mem_we,
  output logic [1:0] ext_mode,
  output logic [1:0] st_size
`ifdef MISALIGN_CHECK_EN
  , output logic     exc_misalign
`endif
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t     r_state, w_next;
  logic [2:0] r_op;
  logic [1:0] r_addr;
  logic       w_accept, w_zero, w_unused_addr;

  // Reserved op is dropped in IDLE; anything else starts a sequence
  assign w_accept = (r_state == S_IDLE) && start && (op != OP_RSV);

  // Address low bits are kept with the op for datapath debug visibility
  assign w_unused_addr = ^r_addr;

  lat_counter #(.W(CW)) u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (w_accept),
    .dec      (r_state == S_RD_WAIT),
    .load_val (CW'(MEM_LAT - 1)),
    .zero     (w_zero)
  );

  // State register plus captured op fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_op    <= OP_ALU_WB;
      r_addr  <= 2'b00;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op;
        r_addr <= addr_lo;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: w_next = S_IDLE;
      S_IDLE: begin
        if (w_accept) begin
`ifdef MISALIGN_CHECK_EN
          if (is_misaligned(op, addr_lo)) w_next = S_EXC;
          else
`endif
          if (op == OP_ALU_WB)            w_next = S_WB;
          else if (op == OP_SW)           w_next = S_WR;
          else                            w_next = S_RD_WAIT;
        end
      end
      S_RD_WAIT: if (w_zero) w_next = S_LATCH;
      S_LATCH:   w_next = is_load(r_op) ? S_WB : S_WR;
      S_WB, S_WR: w_next = S_IDLE;
`ifdef MISALIGN_CHECK_EN
      S_EXC:     w_next = S_IDLE;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  // Moore output decode; reset masks everything but busy
  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = 1'b0;
    wd_sel     = WD_SRC;
    reg_we     = 1'b0;
    reg_dst_sp = 1'b0;
    mdr_ld     = 1'b0;
    mem_we     = 1'b0;
    ext_mode   = EXT_NONE;
    st_size    = ST_WORD;
`ifdef MISALIGN_CHECK_EN
    exc_misalign = 1'b0;
`endif
    case (r_state)
      S_INIT: begin
        reg_we     = 1'b1;
        reg_dst_sp = 1'b1;
        wd_sel     = SP_INIT_SEL;
      end
      S_LATCH: begin
        mdr_ld   = 1'b1;
        ext_mode = ext_of(r_op);
      end
      S_WB: begin
        reg_we   = 1'b1;
        done     = 1'b1;
        wd_sel   = wd_of(r_op);
        ext_mode = ext_of(r_op);
      end
      S_WR: begin
        mem_we  = 1'b1;
        done    = 1'b1;
        st_size = st_of(r_op);
      end
`ifdef MISALIGN_CHECK_EN
      S_EXC: begin
        done         = 1'b1;
        exc_misalign = 1'b1;
      end
`endif
      default: ;
    endcase
    if (reset) begin
      busy       = 1'b1;
      done       = 1'b0;
      wd_sel     = WD_SRC;
      reg_we     = 1'b0;
      reg_dst_sp = 1'b0;
      mdr_ld     = 1'b0;
      mem_we     = 1'b0;
      ext_mode   = EXT_NONE;
      st_size    = ST_WORD;
`ifdef MISALIGN_CHECK_EN
      exc_misalign = 1'b0;
`endif
    end
  end

endmodule

// File: doc/mem_wb_sequencer.md
Name: mem_wb_sequencer

Overview:
- Multicycle-datapath controller that sequences register writeback and memory accesses.
- Drives the 4-bit writedata mux select:
  - 0 = write_src mux output
  - 1 = raw memory word
  - 2 = sign/zero-extended memory data
  - 3 = constant 227
- Also drives memory write enable, MDR load, register write enable and extender mode.
- Sits between the main control FSM (which issues one op per `start`) and the datapath; also performs the post-reset $sp initialisation to 227.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (legal 1..4), counted from address presentation to valid mem_out.
- SP_INIT_SEL, 4'b0011, writedata select code that yields the $sp reset constant 227.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle op request; sampled only in IDLE
- op  in  3  000 ALU_WB, 001 LW, 010 LH, 011 LB, 100 SW, 101 SH, 110 SB, 111 reserved
- addr_lo  in  2  effective address bits [1:0]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on the op's final cycle
- wd_sel  out  4  writedata mux select
- reg_we  out  1  register file write enable
- reg_dst_sp  out  1  forces register destination to 29
- mdr_ld  out  1  MDR load enable
- mem_we  out  1  memory write enable
- ext_mode  out  2  extender mode: 00 none, 01 byte, 10 half
- st_size  out  2  store size: 00 word, 01 half, 10 byte
- exc_misalign  out  1  misalignment pulse; present only with the optional feature

Behaviour:
- **Reset.** reset=1 at a clock edge sets state=INIT and wait counter=0.
  - All outputs are 0 while in reset, except busy=1.
  - Reset mid-operation aborts the op: no mem_we, reg_we or done in the reset cycle or after it.
- **INIT** (first cycle after reset deasserts):
  - reg_we=1, reg_dst_sp=1, wd_sel=SP_INIT_SEL, busy=1.
  - Next state IDLE. `start` is ignored in INIT.
- **IDLE:**
  - All outputs 0 and wd_sel=0.
  - start=1 with op≠111 captures op and addr_lo, then branches.
  - op=111 is ignored: stay IDLE, no done.
- **ALU_WB:** one WB cycle with reg_we=1, wd_sel=0, done=1, then IDLE.
- **Loads:** RD_WAIT for MEM_LAT cycles (counter counts down from MEM_LAT-1 to 0) → LATCH (mdr_ld=1) → WB → IDLE.
  - WB cycle: reg_we=1, done=1.
  - LW: wd_sel=1, ext_mode=00.
  - LH: wd_sel=2, ext_mode=10.
  - LB: wd_sel=2, ext_mode=01.
  - ext_mode is held from LATCH through WB.
  - Latency from start to done: MEM_LAT+2 cycles.
- **SW:** one WR cycle with mem_we=1, st_size=00, done=1, then IDLE.
- **SH/SB** (read-modify-write): RD_WAIT (MEM_LAT) → LATCH (mdr_ld=1) → WR → IDLE.
  - WR cycle: mem_we=1, st_size=01 (SH) or 10 (SB), done=1.
- **Output hygiene:**
  - mem_we and reg_we are never high in the same cycle.
  - wd_sel is nonzero only in a cycle where reg_we=1.
- **start while busy:** ignored and not queued.
- **Encoding:** states are INIT, IDLE, RD_WAIT, LATCH, WB, WR, EXC. Outputs are registered-state decoded (Moore).

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- When defined, misalignment is checked on `start`. Misaligned means:
  - LW/SW with addr_lo≠00, or
  - LH/SH with addr_lo[0]=1.
- A misaligned op enters EXC for one cycle: exc_misalign=1, done=1, no mem_we/reg_we/mdr_ld. Next state IDLE.
- When undefined: addr_lo is only latched, no checks are made, the EXC state and the exc_misalign port are absent, and the access proceeds.

Decomposition:
- Shared package (`mem_wb_pkg`) holds:
  - op codes
  - wd_sel codes (WD_SRC=0, WD_MEM=1, WD_EXT=2, WD_SP=3)
  - ext_mode and st_size codes
  - state enumeration
  - SP_REG=29
- Sub-module `lat_counter`: loadable down-counter sized for MEM_LAT; asserts `zero`.
- The FSM stays in a single module.

Test Plan:
- Reset 3 cycles, then release → exactly one cycle with reg_we=1, reg_dst_sp=1, wd_sel=3; busy falls the next cycle.
- MEM_LAT=2, start LB addr_lo=01 → mdr_ld at cycle 3, reg_we+wd_sel=2+ext_mode=01+done at cycle 4; busy low at cycle 5.
- start SH MEM_LAT=1 → mdr_ld cycle 2, mem_we+st_size=01+done cycle 3, reg_we never high; SW → mem_we+done at cycle 1.
- start LW, pulse start again with op=SW in RD_WAIT → second start ignored, only the LW completes, one done.
- Assert reset during LATCH of an SB → no mem_we ever, INIT replays $sp write, IDLE follows.
- MISALIGN_CHECK_EN, LH addr_lo=11 → one cycle exc_misalign=1, done=1, no mdr_ld/reg_we; LH addr_lo=10 completes normally.
